// File: rtl/ram_queue_ctrl.sv
// ram_queue_ctrl: circular-buffer FIFO controller for the 384x8 dual-port RAMqueue.
// Owns the write/read pointers, the occupancy count, the sticky error flags and
// the RAM strobes. The RAM has a registered read, so popped data appears on dout
// one clock after an accepted pop, qualified by dout_vld.
//
// Optional feature macro: RAMQ_OVERWRITE_EN
//   defined   - a push into a full queue with no pop overwrites the oldest entry
//               (circular capture of the newest DEPTH samples); ovfl is set
//   undefined - a push into a full queue is dropped; ovfl is set
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   clr               synchronous flush of pointers, count and flags
//   push, din         write request and data
//   pop               read request
//   dout, dout_vld    popped data and its one-cycle valid pulse
//   full, empty       occupancy flags
//   count             occupancy 0..DEPTH
//   ovfl, unfl        sticky overflow / underflow flags
//   ram_we, ram_waddr, ram_wdata, ram_raddr   RAM control outputs
//   ram_rdata         RAM registered read data
module ram_queue_ctrl #(
  parameter int unsigned DEPTH = 384,
  parameter int unsigned AW    = 9,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] count,
  output logic          ovfl,
  output logic          unfl,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rdata
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] count_q, count_d;
  logic          ovfl_q, ovfl_d;
  logic          unfl_q, unfl_d;
  logic          dout_vld_q, dout_vld_d;

  logic push_acc;  // RAM write happens this cycle
  logic push_inc;  // accepted push that grows the occupancy
  logic pop_acc;
  logic rd_adv;

  // Wrap at DEPTH-1; DEPTH need not be a power of two.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == AW'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    pop_acc = pop & ~empty & ~clr;
    push_inc = push & ~full & ~clr;
`ifdef RAMQ_OVERWRITE_EN
    // A simultaneous pop takes precedence when full, so the RAM never reads and
    // writes the same address in one cycle.
    push_acc = push & ~clr & (~full | ~pop);
    rd_adv   = pop_acc | (push_acc & full);
`else
    push_acc = push_inc;
    rd_adv   = pop_acc;
`endif

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovfl_d     = ovfl_q;
    unfl_d     = unfl_q;
    dout_vld_d = pop_acc;

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovfl_d   = 1'b0;
      unfl_d   = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = next_ptr(wr_ptr_q);
      if (rd_adv)   rd_ptr_d = next_ptr(rd_ptr_q);
      if (push_inc && !pop_acc) begin
        count_d = count_q + 1'b1;
      end else if (pop_acc && !push_inc) begin
        count_d = count_q - 1'b1;
      end
      if (push && full)  ovfl_d = 1'b1;
      if (pop && empty)  unfl_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovfl_q     <= 1'b0;
      unfl_q     <= 1'b0;
      dout_vld_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovfl_q     <= ovfl_d;
      unfl_q     <= unfl_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign count     = count_q;
  assign ovfl      = ovfl_q;
  assign unfl      = unfl_q;
  assign dout_vld  = dout_vld_q;
  assign dout      = ram_rdata;
  assign ram_we    = push_acc;
  assign ram_waddr = wr_ptr_q;
  assign ram_wdata = din;
  assign ram_raddr = rd_ptr_q;

endmodule

// File: tb/tb_ram_queue_ctrl.sv
// Bench for ram_queue_ctrl: a queue-based reference model plus a RAM model,
// a per-cycle compare process and directed scenarios with literal expectations.
module tb_ram_queue_ctrl;
  localparam int DEPTH = 384;
`ifdef RAMQ_OVERWRITE_EN
  localparam bit Ovw = 1'b1;
`else
  localparam bit Ovw = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, clr, push, pop;
  logic [7:0] din, dout, ram_wdata, ram_rdata;
  logic       dout_vld, full, empty, ovfl, unfl, ram_we;
  logic [8:0] count, ram_waddr, ram_raddr;

  always #5 clk = ~clk;

  ram_queue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .din(din), .pop(pop),
    .dout(dout), .dout_vld(dout_vld), .full(full), .empty(empty), .count(count),
    .ovfl(ovfl), .unfl(unfl), .ram_we(ram_we), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  // RAM with one-clock registered read
  logic [7:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: contents as a queue, head = RAM address of the oldest entry
  logic [7:0] m_q[$];
  int         m_head = 0;
  bit         m_ovfl = 0, m_unfl = 0, m_vld = 0;
  logic [7:0] m_data = 8'h00;

  always @(posedge clk) begin
    int sz;
    sz = m_q.size();
    if (!rst_n || clr) begin
      m_q.delete();
      m_head = 0; m_ovfl = 0; m_unfl = 0; m_vld = 0;
    end else begin
      m_vld = 0;
      if (pop && sz > 0) begin
        m_data = m_q.pop_front();
        m_head = (m_head + 1) % DEPTH;
        m_vld  = 1;
      end else if (pop) begin
        m_unfl = 1;
      end
      if (push && sz < DEPTH) begin
        m_q.push_back(din);
      end else if (push) begin
        m_ovfl = 1;
        if (Ovw && !pop) begin
          void'(m_q.pop_front());
          m_head = (m_head + 1) % DEPTH;
          m_q.push_back(din);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int  sz;
      bit  exp_we;
      sz = m_q.size();
      check("count", count, sz);
      check("full", full, sz == DEPTH);
      check("empty", empty, sz == 0);
      check("ovfl", ovfl, m_ovfl);
      check("unfl", unfl, m_unfl);
      check("dout_vld", dout_vld, m_vld);
      if (m_vld) check("dout", dout, m_data);
      if (rst_n) begin
        exp_we = push && !clr && (sz < DEPTH || (Ovw && !pop));
        check("ram_we", ram_we, exp_we);
        check("ram_raddr", ram_raddr, m_head);
        if (exp_we) begin
          check("ram_waddr", ram_waddr, (m_head + sz) % DEPTH);
          check("ram_wdata", ram_wdata, din);
        end
      end
    end
  end

  task automatic step(input bit p, input logic [7:0] d, input bit o, input bit c);
    push = p; din = d; pop = o; clr = c;
    @(posedge clk);
    #1;
    push = 0; pop = 0; clr = 0;
  endtask

  task automatic fill_ramp(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) step(1, base + 8'(i), 0, 0);
  endtask

  initial begin
    rst_n = 0; clr = 0; push = 0; pop = 0; din = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1; chk_en = 1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);

    // 1: single push/pop
    push = 1; din = 8'hAB;
    #1;
    check("t1_we", ram_we, 1);
    check("t1_waddr", ram_waddr, 0);
    @(posedge clk); #1; push = 0;
    step(0, 0, 1, 0);
    check("t1_vld", dout_vld, 1);
    check("t1_dout", dout, 8'hAB);
    check("t1_empty", empty, 1);

    // 2: fill to DEPTH and drain
    step(0, 0, 0, 1);
    fill_ramp(DEPTH, 8'h00);
    check("t2_full", full, 1);
    check("t2_count", count, 384);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1, 0);
      check("t2_dout", dout, i % 256);
      if (i == DEPTH - 2) check("t2_raddr_last", ram_raddr, 383);
    end
    check("t2_raddr_wrap", ram_raddr, 0);
    check("t2_empty", empty, 1);

    // 3: underflow
    step(0, 0, 1, 0);
    check("t3_vld", dout_vld, 0);
    check("t3_unfl", unfl, 1);
    check("t3_count0", count, 0);
    step(1, 8'h11, 1, 0);
    check("t3_count1", count, 1);
    check("t3_unfl2", unfl, 1);
    step(0, 0, 0, 1);

    // 4: push into full
    fill_ramp(DEPTH, 8'h00);
    push = 1; din = 8'hEE;
    #1;
    check("t4_we", ram_we, Ovw);
    @(posedge clk); #1; push = 0;
    check("t4_ovfl", ovfl, 1);
    check("t4_count", count, 384);
    step(0, 0, 1, 0);
    check("t4_dout", dout, Ovw ? 8'h01 : 8'h00);
`ifdef RAMQ_OVERWRITE_EN
    check("t4_mem0", mem[0], 8'hEE);
`endif
    step(0, 0, 0, 1);

    // 5: simultaneous push/pop
    fill_ramp(5, 8'h10);
    step(1, 8'hCD, 1, 0);
    check("t5_count", count, 5);
    check("t5_dout", dout, 8'h10);
    step(0, 0, 0, 1);
    fill_ramp(DEPTH, 8'h00);
    step(1, 8'h55, 1, 0);
    check("t5_ovfl", ovfl, 1);
    check("t5_count_full", count, 383);
    check("t5_dout_full", dout, 8'h00);
    step(0, 0, 0, 1);

    // 6: flush / reset with a pop in flight
    step(0, 0, 1, 0);
    fill_ramp(10, 8'h20);
    step(0, 0, 1, 1);
    check("t6_vld", dout_vld, 0);
    check("t6_count", count, 0);
    check("t6_empty", empty, 1);
    check("t6_ovfl", ovfl, 0);
    check("t6_unfl", unfl, 0);
    step(0, 0, 1, 0);
    fill_ramp(10, 8'h30);
    rst_n = 0;
    step(0, 0, 1, 0);
    rst_n = 1;
    check("t6r_vld", dout_vld, 0);
    check("t6r_count", count, 0);
    check("t6r_unfl", unfl, 0);
    step(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
